station_xy_nport: RTL
=====================

# station_xy_nport

Parametrised N-lane routing station that sits between one engine and N ring channels. Each lane buffers incoming threads (PC plus flag) in a FIFO and either removes them from the ring for the local engine or passes them through to the matching output lane. Threads emitted by the engine are injected into whichever output lane is free. The block reports occupancy and activity to the top-level scheduler.

## Interface
Parameters:
- PC_WIDTH, 8: thread PC width. Payload width W = PC_WIDTH+1.
- N_PORTS, 2: ring lanes, 2..8.
- FIFO_DEPTH, 4: entries per lane FIFO, power of two, at least 2.
- ENGINE_PRIORITY, 1: 1 = heads are offered to the engine before pass-through; 0 = a head goes to the engine only when its output lane is not ready.

Ports:
- clk, in, 1: single clock.
- rst, in, 1: reset, asynchronous, active-low.
- in_valid / in_ready, in / out, N_PORTS each: per-lane ring input handshake.
- in_data, in, N_PORTS*W: lane i occupies bits [i*W +: W].
- out_valid / out_ready, out / in, N_PORTS each: per-lane ring output handshake.
- out_data, out, N_PORTS*W: per-lane ring output payload.
- eng_in_valid / eng_in_ready, out / in, 1 each: handshake from station to engine.
- eng_in_data, out, W: payload from station to engine.
- eng_out_valid / eng_out_ready, in / out, 1 each: handshake from engine to station.
- eng_out_data, in, W: payload from engine to station.
- engine_running / engine_full, in, 1 each: status inputs from the engine.
- bb_running / bb_full, out, 1 each: aggregated status outputs.

## Operation
- Transfers happen when valid && ready in the same cycle. Payloads are never altered or duplicated.
- Per-lane FIFO:
  - in_ready[i] = (count_i < FIFO_DEPTH).
  - No write while full, even if the FIFO pops in the same cycle.
  - Push and pop in the same cycle leave count unchanged.
- Engine grant:
  - Candidates are non-empty lanes. ENGINE_PRIORITY=0 additionally requires !out_ready[i].
  - Winner = first candidate at or after rr_eng, scanning circularly.
  - eng_in_valid = any candidate. eng_in_data = winner head.
  - On transfer, pop the winner and set rr_eng = winner+1 mod N_PORTS. With no transfer, rr_eng is held.
- Pass-through:
  - Every non-empty lane that is not the granted engine winner drives out_valid[i] with its head. The winner lane does not drive its output.
  - When eng_in_ready=0, every non-empty lane drives its output and no grant is made.
- Injection:
  - Pass-through has absolute priority on each output lane.
  - Lane j is free when it is not driving pass-through.
  - eng_out_ready = some free lane has out_ready[j]=1.
  - The chosen lane is the first free, ready lane at or after rr_inj, scanning circularly. The chosen lane drives out_valid=1 with eng_out_data.
  - On transfer, rr_inj = chosen+1 mod N_PORTS.
- Status:
  - bb_running = any count_i != 0 || eng_out_valid || engine_running.
  - bb_full = all in_ready low && engine_full.

## Timing
- Reset (rst=0): all counts, pointers, rr_eng and rr_inj are cleared to 0.
- While reset is asserted, all out_valid, eng_in_valid and eng_out_ready are 0, and in_ready is forced to 0.
- After deassertion, in_ready is all 1. bb_running follows its inputs; it is 0 with idle inputs. bb_full is 0.
- A reset mid-operation discards all buffered threads, with no partial output.
- Latency:
  - in to out or eng_in: 1 cycle minimum. A write in cycle t is visible at the head in t+1; there is no fall-through.
  - eng_out to out: 0 cycles (combinational injection).
- Output signals are combinational from registered FIFO state and the current ready/valid inputs. There are no combinational paths from in_valid to any output.
- Wrap-around: FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. Counts are log2(FIFO_DEPTH)+1 bits.
- Full: count saturates at FIFO_DEPTH with in_ready=0.
- Empty: no valid is driven from that lane.

## Structure
- Package station_pkg holds:
  - payload width function pl_w(PC_WIDTH);
  - typedef of the lane status struct {valid, data};
  - function rr_pick(req, ptr), returning {found, index}.
- Sub-module station_lane_fifo:
  - parameters W and FIFO_DEPTH;
  - ports push, pop, data in/out, count, full, empty;
  - instanced N_PORTS times.
- Top level holds the grant, pass-through and injection logic and the two round-robin pointers.

## Test plan
- Reset with rst=0 held 3 cycles, then released:
  - all out_valid=0, in_ready=4'b1111 (N_PORTS=4), bb_full=0;
  - bb_running=0 with idle inputs.
- Fill lane 0 with 4 writes, out_ready=0, eng_in_ready=0:
  - in_ready[0]=0 after the 4th write; count stays 4;
  - the 5th write is refused.
- Engine fairness, ENGINE_PRIORITY=1, lanes 0..2 each holding payloads 0x10/0x20/0x30, eng_in_ready=1, out_ready=0:
  - engine receives 0x10, 0x20, 0x30 on consecutive cycles;
  - rr_eng ends at 3.
- ENGINE_PRIORITY=0, lane 1 holds 0x55 with out_ready[1]=1:
  - 0x55 appears on out[1], eng_in_valid=0.
  - With out_ready[1]=0 instead, 0x55 goes to the engine.
- Injection, lanes 0/1 passing traffic, lanes 2/3 empty and ready, eng_out_data=0x1A1 held 2 cycles:
  - injected on out[2], then out[3];
  - pass-through data unchanged.
- Reset asserted mid-stream with 3 entries buffered:
  - outputs go invalid immediately (asynchronously);
  - after release, counts are 0 and no stale payload appears.

Source files
------------

// File: rtl/station_pkg.sv
// Shared types and helpers for the N-lane routing station.
package station_pkg;

    localparam int unsigned MAX_PORTS = 8;
    localparam int unsigned IDX_W     = $clog2(MAX_PORTS);
    localparam int unsigned PL_W_MAX  = 33;

    // Round-robin pick result: {found, index}
    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] index;
    } rr_pick_t;

    // Per-lane head status; data sized for the widest supported payload
    typedef struct packed {
        logic                valid;
        logic [PL_W_MAX-1:0] data;
    } lane_status_t;

    // Payload width: PC plus one flag bit
    function automatic int unsigned pl_w(input int unsigned pc_width);
        return pc_width + 1;
    endfunction

    // First set request at or after ptr, scanning circularly over MAX_PORTS.
    // Requests above the real lane count are zero, so this matches a scan
    // modulo the real lane count as long as ptr is below it.
    function automatic rr_pick_t rr_pick(input logic [MAX_PORTS-1:0] req,
                                         input logic [IDX_W-1:0]     ptr);
        rr_pick_t         res;
        logic [IDX_W-1:0] idx;
        res = '0;
        for (int unsigned k = 0; k < MAX_PORTS; k++) begin
            idx = ptr + IDX_W'(k);
            if (!res.found && req[idx]) begin
                res.found = 1'b1;
                res.index = idx;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/station_lane_fifo.sv
// Per-lane thread FIFO: registered head, no fall-through, refuses writes when full.
module station_lane_fifo
    import station_pkg::*;
#(
    parameter int unsigned W          = 9,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned AW        = $clog2(FIFO_DEPTH),
    localparam int unsigned CW        = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  data_i,
    output logic [W-1:0]  data_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [W-1:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(FIFO_DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Next pointers and occupancy; pointers wrap naturally
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    // Pointer and count registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count gates every read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/station_xy_nport.sv
// N-lane routing station: lane FIFOs, engine grant, pass-through and injection.
module station_xy_nport
    import station_pkg::*;
#(
    parameter int unsigned PC_WIDTH        = 8,
    parameter int unsigned N_PORTS         = 2,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned ENGINE_PRIORITY = 1,
    localparam int unsigned W              = pl_w(PC_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_PORTS-1:0]     in_valid,
    output logic [N_PORTS-1:0]     in_ready,
    input  logic [N_PORTS*W-1:0]   in_data,
    output logic [N_PORTS-1:0]     out_valid,
    input  logic [N_PORTS-1:0]     out_ready,
    output logic [N_PORTS*W-1:0]   out_data,
    output logic                   eng_in_valid,
    input  logic                   eng_in_ready,
    output logic [W-1:0]           eng_in_data,
    input  logic                   eng_out_valid,
    output logic                   eng_out_ready,
    input  logic [W-1:0]           eng_out_data,
    input  logic                   engine_running,
    input  logic                   engine_full,
    output logic                   bb_running,
    output logic                   bb_full
);

    localparam int unsigned      CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PORTS - 1);

    logic [N_PORTS-1:0] lane_empty, lane_full, lane_pop, lane_busy;
    logic [W-1:0]       lane_head  [N_PORTS];
    logic [CW-1:0]      lane_count [N_PORTS];
    logic [N_PORTS-1:0] eng_cand, pass_en, inj_req;
    logic [IDX_W-1:0]   rr_eng_q, rr_eng_d, rr_inj_q, rr_inj_d;
    rr_pick_t           eng_pick, inj_pick;
    logic               eng_take, inj_take;

    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
    endfunction

    // One FIFO per ring lane; in_ready is forced low while in reset
    for (genvar g = 0; g < N_PORTS; g++) begin : g_lane
        station_lane_fifo #(
            .W          (W),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push_i  (in_valid[g]),
            .pop_i   (lane_pop[g]),
            .data_i  (in_data[g*W +: W]),
            .data_o  (lane_head[g]),
            .count_o (lane_count[g]),
            .full_o  (lane_full[g]),
            .empty_o (lane_empty[g])
        );
        assign in_ready[g]  = rst & ~lane_full[g];
        assign lane_busy[g] = |lane_count[g];
    end

    assign bb_running = (|lane_busy) | eng_out_valid | engine_running;
    assign bb_full    = (&lane_full) & engine_full;

    // Grant a head to the engine, pass the rest through, inject into free lanes
    always_comb begin
        eng_cand      = '0;
        pass_en       = '0;
        inj_req       = '0;
        lane_pop      = '0;
        out_valid     = '0;
        out_data      = '0;
        eng_in_valid  = 1'b0;
        eng_in_data   = '0;
        eng_out_ready = 1'b0;
        eng_pick      = '0;
        inj_pick      = '0;
        eng_take      = 1'b0;
        inj_take      = 1'b0;
        rr_eng_d      = rr_eng_q;
        rr_inj_d      = rr_inj_q;
        if (rst) begin
            for (int unsigned i = 0; i < N_PORTS; i++) begin
                eng_cand[i] = !lane_empty[i] && (ENGINE_PRIORITY != 0 || !out_ready[i]);
            end
            eng_pick     = rr_pick(MAX_PORTS'(eng_cand), rr_eng_q);
            eng_in_valid = eng_pick.found;
            eng_take     = eng_pick.found && eng_in_ready;
            for (int unsigned i = 0; i < N_PORTS; i++) begin
                if (eng_pick.found && eng_pick.index == IDX_W'(i)) begin
                    eng_in_data = lane_head[i];
                end
                pass_en[i] = !lane_empty[i] && !(eng_take && eng_pick.index == IDX_W'(i));
                inj_req[i] = !pass_en[i] && out_ready[i];
            end
            inj_pick      = rr_pick(MAX_PORTS'(inj_req), rr_inj_q);
            eng_out_ready = inj_pick.found;
            inj_take      = eng_out_valid && inj_pick.found;
            for (int unsigned i = 0; i < N_PORTS; i++) begin
                if (pass_en[i]) begin
                    out_valid[i]      = 1'b1;
                    out_data[i*W +: W] = lane_head[i];
                end else if (inj_take && inj_pick.index == IDX_W'(i)) begin
                    out_valid[i]      = 1'b1;
                    out_data[i*W +: W] = eng_out_data;
                end
                lane_pop[i] = (pass_en[i] && out_ready[i]) ||
                              (eng_take && eng_pick.index == IDX_W'(i));
            end
            if (eng_take) begin
                rr_eng_d = rr_next(eng_pick.index);
            end
            if (inj_take) begin
                rr_inj_d = rr_next(inj_pick.index);
            end
        end
    end

    // Round-robin pointers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_eng_q <= '0;
            rr_inj_q <= '0;
        end else begin
            rr_eng_q <= rr_eng_d;
            rr_inj_q <= rr_inj_d;
        end
    end

endmodule
